// File: rtl/seg7_scan_rx_pkg.sv
// seg7_pkg: shared seven-segment definitions.
//   SEG7_0..SEG7_9 : active-high patterns, a=bit0 .. g=bit6 (shared with the encoder)
//   seg7_to_bcd    : exact-match decode returning {valid, digit[3:0]}
//   SEG_IDLE/AN_IDLE : inactive level of the active-low display pins
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int AN_W  = 4;
  localparam int VAL_W = 7;

  localparam logic [SEG_W-1:0] SEG7_0 = 7'h3F; // a b c d e f
  localparam logic [SEG_W-1:0] SEG7_1 = 7'h06; // b c
  localparam logic [SEG_W-1:0] SEG7_2 = 7'h5B; // a b d e g
  localparam logic [SEG_W-1:0] SEG7_3 = 7'h4F; // a b c d g
  localparam logic [SEG_W-1:0] SEG7_4 = 7'h66; // b c f g
  localparam logic [SEG_W-1:0] SEG7_5 = 7'h6D; // a c d f g
  localparam logic [SEG_W-1:0] SEG7_6 = 7'h7D; // a c d e f g
  localparam logic [SEG_W-1:0] SEG7_7 = 7'h07; // a b c
  localparam logic [SEG_W-1:0] SEG7_8 = 7'h7F; // all
  localparam logic [SEG_W-1:0] SEG7_9 = 7'h6F; // a b c d f g

  // Pins are active-low, so "nothing driven" is all ones.
  localparam logic [SEG_W-1:0] SEG_IDLE = '1;
  localparam logic [AN_W-1:0]  AN_IDLE  = '1;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } bcd_t;

  function automatic bcd_t seg7_to_bcd(input logic [SEG_W-1:0] pat);
    bcd_t r;
    r.valid = 1'b1;
    r.digit = 4'd0;
    case (pat)
      SEG7_0:  r.digit = 4'd0;
      SEG7_1:  r.digit = 4'd1;
      SEG7_2:  r.digit = 4'd2;
      SEG7_3:  r.digit = 4'd3;
      SEG7_4:  r.digit = 4'd4;
      SEG7_5:  r.digit = 4'd5;
      SEG7_6:  r.digit = 4'd6;
      SEG7_7:  r.digit = 4'd7;
      SEG7_8:  r.digit = 4'd8;
      SEG7_9:  r.digit = 4'd9;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_rx_if.sv
// seg7_scan_rx_if: display pins plus decoded-value report.
//   seg[6:0], an[3:0] : active-low display pins (driven by master)
//   value, value_valid, value_stable, present, err_pattern, err_an : monitor report
//   master : display-side / bench view, slave : monitor view
interface seg7_scan_rx_if;
  import seg7_pkg::*;

  logic [SEG_W-1:0] seg;
  logic [AN_W-1:0]  an;
  logic [VAL_W-1:0] value;
  logic             value_valid;
  logic             value_stable;
  logic             present;
  logic             err_pattern;
  logic             err_an;

  modport master (
    output seg, an,
    input  value, value_valid, value_stable, present, err_pattern, err_an
  );

  modport slave (
    input  seg, an,
    output value, value_valid, value_stable, present, err_pattern, err_an
  );
endinterface

// File: rtl/seg7_scan_rx_dwell.sv
// seg7_dwell: pin synchronizer and anode dwell tracker.
//   clk, rst     : clock, async active-high reset
//   seg_i, an_i  : raw active-low pins
//   seg_s_o      : synchronized segment lines
//   sample_o     : one-cycle strobe, the synchronized anode pattern has held SETTLE cycles
//   sel_units_o  : an_s[0] low, sel_tens_o : an_s[1] low
//   multi_o      : more than one anode low
module seg7_dwell
  import seg7_pkg::*;
#(
  parameter int SETTLE = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_i,
  input  logic [AN_W-1:0]  an_i,
  output logic [SEG_W-1:0] seg_s_o,
  output logic             sample_o,
  output logic             sel_units_o,
  output logic             sel_tens_o,
  output logic             multi_o
);

  localparam int              CW      = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SETTLE - 1);
  localparam int              PW      = SEG_W + AN_W;

  // Two-flop synchronizer, {an, seg} per stage. Reset to the idle pin level
  // so the monitor never sees a phantom "all anodes low" after reset.
  logic [1:0][PW-1:0] sync_q;
  logic [AN_W-1:0]    an_s, an_prev_q, lo;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               taken_q, taken_d, chg;

  assign an_s    = sync_q[1][SEG_W +: AN_W];
  assign seg_s_o = sync_q[1][SEG_W-1:0];

  // cnt_d is "cycles an_s has held, minus one", including the current cycle.
  always_comb begin
    chg      = (an_s != an_prev_q);
    cnt_d    = chg ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));
    sample_o = (cnt_d == CNT_MAX) && !taken_q;
    taken_d  = chg ? 1'b0 : (taken_q || sample_o);
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign lo          = ~an_s;
  assign multi_o     = |(lo & (lo - AN_W'(1)));
  assign sel_units_o = lo[0];
  assign sel_tens_o  = lo[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {2{AN_IDLE, SEG_IDLE}};
      an_prev_q <= AN_IDLE;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
    end else begin
      sync_q[0] <= {an_i, seg_i};
      sync_q[1] <= sync_q[0];
      an_prev_q <= an_s;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
    end
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: receive-side monitor of a multiplexed two-digit 7-segment bus.
//   clk, rst : clock, async active-high reset
//   bus      : seg7_scan_rx_if.slave (pins in, value/flags out)
// Captures units (an[0]) and tens (an[1]) digits at each settled dwell,
// reports tens*10+units when both are captured, and tracks stability and
// liveness of the frame stream.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int SETTLE        = 1024,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT       = 2**20
) (
  input  logic          clk,
  input  logic          rst,
  seg7_scan_rx_if.slave bus
);

  localparam int            SW       = $clog2(STABLE_FRAMES + 1);
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  logic [SEG_W-1:0] seg_s;
  logic             sample, sel_units, sel_tens, multi;

  seg7_dwell #(.SETTLE(SETTLE)) u_dwell (
    .clk         (clk),
    .rst         (rst),
    .seg_i       (bus.seg),
    .an_i        (bus.an),
    .seg_s_o     (seg_s),
    .sample_o    (sample),
    .sel_units_o (sel_units),
    .sel_tens_o  (sel_tens),
    .multi_o     (multi)
  );

  bcd_t             dec;
  logic [3:0]       units_q, units_d, tens_q, tens_d;
  logic             u_ok_q, u_ok_d, t_ok_q, t_ok_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             vv_q, err_pat_q, err_pat_d, err_an_q, err_an_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             present_q, present_d, frame;

  always_comb begin
    dec       = seg7_to_bcd(~seg_s);
    units_d   = units_q;
    tens_d    = tens_q;
    u_ok_d    = u_ok_q;
    t_ok_d    = t_ok_q;
    err_pat_d = 1'b0;
    err_an_d  = 1'b0;

    // An an[3:2]-only or all-high dwell falls through with no action.
    if (sample) begin
      if (multi) begin
        err_an_d = 1'b1;
      end else if (sel_units) begin
        u_ok_d    = dec.valid;
        err_pat_d = !dec.valid;
        if (dec.valid) units_d = dec.digit;
      end else if (sel_tens) begin
        t_ok_d    = dec.valid;
        err_pat_d = !dec.valid;
        if (dec.valid) tens_d = dec.digit;
      end
    end

    // Completion is evaluated on the post-capture flags so the frame is
    // reported one cycle after the second digit's sample.
    frame   = u_ok_d && t_ok_d;
    value_d = value_q;
    stab_d  = stab_q;
    tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
    if (frame) begin
      value_d = VAL_W'(tens_d) * VAL_W'(10) + VAL_W'(units_d);
      stab_d  = (value_d != value_q) ? SW'(1)
              : ((stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1));
      tmo_d   = '0;
      u_ok_d  = 1'b0;
      t_ok_d  = 1'b0;
    end

    // present is held in a flop (not derived from tmo) so it reads 0 out of reset.
    present_d = frame || (present_q && (tmo_d < TMO_MAX));
    if (present_q && !present_d) stab_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units_q   <= '0;
      tens_q    <= '0;
      u_ok_q    <= 1'b0;
      t_ok_q    <= 1'b0;
      value_q   <= '0;
      vv_q      <= 1'b0;
      err_pat_q <= 1'b0;
      err_an_q  <= 1'b0;
      stab_q    <= '0;
      tmo_q     <= '0;
      present_q <= 1'b0;
    end else begin
      units_q   <= units_d;
      tens_q    <= tens_d;
      u_ok_q    <= u_ok_d;
      t_ok_q    <= t_ok_d;
      value_q   <= value_d;
      vv_q      <= frame;
      err_pat_q <= err_pat_d;
      err_an_q  <= err_an_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      present_q <= present_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.value_valid  = vv_q;
  assign bus.value_stable = (stab_q == STAB_MAX);
  assign bus.present      = present_q;
  assign bus.err_pattern  = err_pat_q;
  assign bus.err_an       = err_an_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb_seg7_scan_rx: directed + randomized bench for seg7_scan_rx with a
// cycle-level behavioural model (pin history, dwell run lengths, edge-count
// timeout) compared against the DUT on every falling edge.
module tb_seg7_scan_rx;
  localparam int SETTLE = 4;
  localparam int SF     = 2;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_rx_if bus();

  seg7_scan_rx #(.SETTLE(SETTLE), .STABLE_FRAMES(SF), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Active-high segment patterns for 0..9, a = bit0.
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_chk  = 0;
  int n_pass = 0;
  int vv_cnt = 0, ep_cnt = 0, ea_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat[i] == p) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  logic [3:0] m_s1_an, m_s2_an, m_prev_an;
  logic [6:0] m_s1_seg, m_s2_seg;
  int m_run, m_units, m_tens, m_val, m_stab, m_edge, m_last;
  bit m_uok, m_tok, m_vv, m_ep, m_ea, m_have, m_present;

  task automatic m_reset();
    m_s1_an = 4'hF; m_s2_an = 4'hF; m_prev_an = 4'hF;
    m_s1_seg = 7'h7F; m_s2_seg = 7'h7F;
    m_run = 1; m_units = 0; m_tens = 0; m_val = 0; m_stab = 0;
    m_edge = 0; m_last = 0;
    m_uok = 0; m_tok = 0; m_vv = 0; m_ep = 0; m_ea = 0;
    m_have = 0; m_present = 0;
  endtask

  task automatic m_step();
    int lows, d, nv;
    bit was;
    m_edge++;
    // m_s2_* are the synchronized pins seen during the cycle that just ended
    if (m_s2_an == m_prev_an) m_run++; else m_run = 1;
    m_prev_an = m_s2_an;
    m_vv = 0; m_ep = 0; m_ea = 0;
    if (m_run == SETTLE) begin
      lows = 0;
      for (int i = 0; i < 4; i++) if (!m_s2_an[i]) lows++;
      d = decode(~m_s2_seg);
      if (lows > 1) m_ea = 1;
      else if (!m_s2_an[0]) begin
        if (d < 0) begin m_ep = 1; m_uok = 0; end
        else begin m_units = d; m_uok = 1; end
      end else if (!m_s2_an[1]) begin
        if (d < 0) begin m_ep = 1; m_tok = 0; end
        else begin m_tens = d; m_tok = 1; end
      end
    end
    if (m_uok && m_tok) begin
      nv = m_tens * 10 + m_units;
      if (nv == m_val) m_stab = (m_stab < SF) ? m_stab + 1 : SF;
      else m_stab = 1;
      m_val = nv; m_vv = 1; m_uok = 0; m_tok = 0;
      m_have = 1; m_last = m_edge;
    end
    was = m_present;
    m_present = m_have && ((m_edge - m_last) < TMO);
    if (was && !m_present) m_stab = 0;
    m_s2_an = m_s1_an; m_s2_seg = m_s1_seg;
    m_s1_an = bus.an;  m_s1_seg = bus.seg;
  endtask

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset(); else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("value",        bus.value,        m_val);
      chk("value_valid",  bus.value_valid,  m_vv);
      chk("value_stable", bus.value_stable, (m_stab == SF));
      chk("present",      bus.present,      m_present);
      chk("err_pattern",  bus.err_pattern,  m_ep);
      chk("err_an",       bus.err_an,       m_ea);
      if (bus.value_valid) vv_cnt++;
      if (bus.err_pattern) ep_cnt++;
      if (bus.err_an)      ea_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int t, input int u);
    dwell(4'b1110, ~pat[u], 10);
    dwell(4'b1101, ~pat[t], 10);
  endtask

  initial begin : drive
    int c_vv, c_ep, c_ea, kind, len;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    dwell(4'hF, 7'h7F, 5);

    // 13, then the same frame again -> stable
    c_vv = vv_cnt;
    frame(1, 3);
    chk("lit13_value", bus.value, 13);
    chk("lit13_model", m_val, 13);
    chk("lit13_once",  vv_cnt - c_vv, 1);
    chk("lit13_present", bus.present, 1);
    frame(1, 3);
    chk("lit13_stable", bus.value_stable, 1);

    // 99 then 05
    frame(9, 9);
    chk("lit99_value", bus.value, 99);
    frame(0, 5);
    chk("lit05_value",  bus.value, 5);
    chk("lit05_stable", bus.value_stable, 0);

    // short tens glitch between full dwells
    c_vv = vv_cnt; c_ep = ep_cnt; c_ea = ea_cnt;
    dwell(4'b1110, ~pat[4], 10);
    dwell(4'b1101, ~pat[8], 3);
    dwell(4'b1110, ~pat[6], 10);
    dwell(4'b1101, ~pat[2], 10);
    chk("glitch_value", bus.value, 26);
    chk("glitch_once",  vv_cnt - c_vv, 1);
    chk("glitch_noerr", (ep_cnt - c_ep) + (ea_cnt - c_ea), 0);

    // blank units
    c_vv = vv_cnt; c_ep = ep_cnt;
    dwell(4'b1110, 7'h7F, 10);
    dwell(4'b1101, ~pat[1], 10);
    chk("blank_errpat", ep_cnt - c_ep, 1);
    chk("blank_novv",   vv_cnt - c_vv, 0);
    dwell(4'b1110, ~pat[7], 10);
    chk("blank_value", bus.value, 17);
    chk("blank_vv",    vv_cnt - c_vv, 1);

    // two anodes low
    c_vv = vv_cnt; c_ea = ea_cnt;
    dwell(4'b1100, ~pat[8], 10);
    chk("multi_erran", ea_cnt - c_ea, 1);
    chk("multi_novv",  vv_cnt - c_vv, 0);

    // timeout
    frame(4, 2);
    frame(4, 2);
    chk("lit42_stable", bus.value_stable, 1);
    dwell(4'hF, 7'h7F, 70);
    chk("tmo_present", bus.present, 0);
    chk("tmo_stable",  bus.value_stable, 0);
    chk("tmo_value",   bus.value, 42);

    // reset mid-dwell
    dwell(4'b1110, ~pat[5], 2);
    rst = 1'b1;
    #1;
    chk("rst_value",   bus.value, 0);
    chk("rst_vv",      bus.value_valid, 0);
    chk("rst_stable",  bus.value_stable, 0);
    chk("rst_present", bus.present, 0);
    chk("rst_errpat",  bus.err_pattern, 0);
    chk("rst_erran",   bus.err_an, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized scan traffic
    repeat (250) begin
      kind = $urandom_range(0, 24);
      len  = $urandom_range(1, 12);
      if (kind < 8)       dwell(4'b1110, ~pat[$urandom_range(0, 9)], len);
      else if (kind < 15) dwell(4'b1101, ~pat[$urandom_range(0, 9)], len);
      else if (kind < 18) dwell(4'($urandom), 7'($urandom), len);
      else if (kind < 20) dwell(4'hF, 7'h7F, len);
      else if (kind < 21) dwell(4'b1011, ~pat[$urandom_range(0, 9)], len);
      else if (kind < 23) dwell(4'b1110, 7'($urandom), len);
      else if (kind < 24) dwell(4'b1100, 7'($urandom), len);
      else                dwell(4'hF, 7'h7F, $urandom_range(60, 80));
    end
    dwell(4'hF, 7'h7F, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receive-side monitor for the multiplexed seven-segment display bus. It samples the active-low segment and anode lines driven by the display scanner and decodes the segment patterns back to BCD digits. It reassembles the two-digit value (units on anode 0, tens on anode 1) and reports it with valid, stable and error flags. It sits on the board-side display pins and gives the controller and the bench a self-check of what is actually shown.

## Interface
- SETTLE, 1024: cycles an anode pattern must hold before its segments are sampled (≥2)
- STABLE_FRAMES, 4: consecutive identical frames required for `value_stable` (≥1)
- TIMEOUT, 2^20: cycles without a completed frame before `present` drops
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg  in  7  segment lines, active-low, seg[0]=a … seg[6]=g
- an  in  4  anode enables, active-low; an[0]=units, an[1]=tens, an[3:2] ignored for value
- value  out  7  last decoded value, tens*10+units, 0..99
- value_valid  out  1  one-cycle pulse when a new frame completes
- value_stable  out  1  value unchanged for STABLE_FRAMES frames
- present  out  1  frames arriving within TIMEOUT
- err_pattern  out  1  one-cycle pulse: sampled pattern is not a digit 0–9
- err_an  out  1  one-cycle pulse: more than one anode low after settle

## Operation
- `seg`/`an` pass through a 2-flop synchronizer. All logic below uses the synchronized copies `seg_s`/`an_s`.
- Settle counter:
  - Clears whenever `an_s` differs from its previous-cycle value; otherwise increments, saturating at SETTLE-1.
  - Sampling happens once per anode dwell, in the cycle the counter first reaches SETTLE-1. A `taken` flag blocks resampling until `an_s` changes.
- At the sample point:
  - All anodes high: no action.
  - More than one anode low: `err_an` pulses; nothing is captured.
  - Exactly one low in an[3:2]: no action.
  - an[0] or an[1] low: decode `~seg_s`.
    - Valid digit: store it in `units`/`tens` and set `u_ok`/`t_ok`.
    - Invalid pattern: `err_pattern` pulses and the corresponding ok flag clears.
- Decoding is exact-match on the standard patterns. Digit 6 uses a,c,d,e,f,g; digit 7 uses a,b,c; digit 9 uses a,b,c,d,f,g. Any other pattern, including blank, is invalid.
- Frame complete when `u_ok && t_ok`, in either order:
  - `value <= tens*10 + units`, computed in 7 bits with no overflow (max 99).
  - `value_valid` pulses; `u_ok`/`t_ok` clear.
- Stability counter:
  - Complete frame equal to the previous `value`: increment, saturating at STABLE_FRAMES.
  - Different frame: reset to 1.
  - `value_stable = (count == STABLE_FRAMES)`.
- Timeout counter:
  - Resets on each complete frame and counts otherwise, saturating at TIMEOUT.
  - `present` = counter < TIMEOUT.
  - When `present` falls, `value_stable` clears (stability counter → 0). `value` holds its last value.

## Timing
- Reset values: `value`=0, `value_valid`=0, `value_stable`=0, `present`=0, `err_pattern`=0, `err_an`=0. All counters, ok flags, `taken` and synchronizers clear.
- Latency:
  - Pin anode change → sample: SETTLE+2 cycles (2 synchronizer cycles + settle).
  - Sample of second digit → `value_valid` high: 1 cycle. `value`, `value_stable` and `present` update in that same cycle.
- `present` rises in the `value_valid` cycle of the first frame after reset or timeout.
- An anode glitch shorter than SETTLE restarts the settle count; no sample is taken from the glitch.
- A `rst` assertion mid-dwell aborts everything immediately. After release, the first sample needs a full SETTLE dwell.
- The error pulses and `value_valid` are exclusive per cycle, since only one sample occurs per cycle.

## Structure
- Package `seg7_pkg`: 7-bit pattern constants SEG7_0…SEG7_9 (active-high, a=bit0) and a `seg7_to_bcd` function returning {valid, digit[3:0]}. The display encoder shares these constants.
- One sub-module, `seg7_dwell`: synchronizer, settle counter, `taken` flag and anode one-hot check. It outputs `sample`, `sel_units`, `sel_tens`, `multi`.
- Top: capture registers, frame assembly, stability and timeout counters.

## Test plan
- SETTLE=4, STABLE_FRAMES=2, TIMEOUT=64: drive an=1110/seg=~SEG7_3 for 10 cycles, then an=1101/seg=~SEG7_1 → `value`=13, `value_valid` pulses once; repeating the frame → `value_stable`=1.
- Tens 9, units 9 → `value`=99. Next frame 0/5 → `value`=5, `value_stable`=0.
- Anode dwell of 3 cycles (<SETTLE) between valid dwells → no capture, no error, frame assembled only from the full dwells.
- seg=~7'b0000000 (blank) on units → `err_pattern` pulse, no `value_valid` until a valid units dwell follows.
- an=1100 held 10 cycles → `err_an` pulses once per dwell, no capture.
- Frames stop for 64 cycles → `present`=0 and `value_stable`=0; assert `rst` mid-dwell → all outputs 0 on the next edge.
